fb_read_scheduler: RTL and testbench

Framebuffer access scheduler between the display sync generator and a single-port synchronous video RAM. Prefetches pixels in raster order into a small FIFO so that one pixel is available every active `pclk`. Grants the RAM to a write requester (drawing engine or CPU bridge) whenever the display fetch does not need it. Consumes the `hen`/`ven`/`vs` outputs of the timing generator and drives the pixel stream toward the colour output stage.

---
 rtl/fb_read_scheduler.sv | 162 ++++++++++++++++
 tb/tb_fb_read_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_read_scheduler.sv
// Framebuffer RAM scheduler: raster-order prefetch into a small FIFO for the display,
// with spare RAM cycles granted to a single write requester. Optional macro: FB_SCHED_UNDERFLOW_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_WAIT  | after reset; no display reads, writes granted freely
// S_FETCH | frame in progress; display reads have strict RAM priority
// S_DONE  | whole frame issued; no display reads, writes granted freely
module fb_read_scheduler #(
    parameter int H_ACT = 800,
    parameter int V_ACT = 600,
    parameter int AW    = 19,
    parameter int DW    = 12,
    parameter int DEPTH = 4
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          hen,
    input  logic          ven,
    input  logic          vs,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pix_out,
    output logic          pix_valid,
    output logic          underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [AW:0] TOTAL = (AW+1)'(H_ACT * V_ACT);

    typedef enum logic [1:0] {S_WAIT, S_FETCH, S_DONE} state_t;

    state_t          state, state_nxt;
    logic            vs_q;
    logic            fs;
    logic            pop;
    logic            rd_issue;
    logic            inflight;
    logic            push;
    logic            store;
    logic            deq;
    logic            fifo_empty;
    logic [AW-1:0]   rd_addr;
    logic [PW:0]     count;
    logic [PW+1:0]   level;
    logic [PW-1:0]   wptr, rptr;
    logic [DW-1:0]   fifo_mem [DEPTH];

    assign fs         = vs & ~vs_q;
    assign pop        = hen & ven;
    assign fifo_empty = (count == '0);
    assign level      = {1'b0, count} + (PW+2)'(inflight);
    assign rd_issue   = (state == S_FETCH) & ~fs & ((level < (PW+2)'(DEPTH)) | pop);
    // read data that returns in a frame-start cycle belongs to the old frame
    assign push       = inflight & ~fs;
    // a pop against an empty FIFO takes the returning word straight through
    assign store      = push & ~(pop & fifo_empty);
    assign deq        = pop & ~fifo_empty;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        if (rd_issue) begin
            mem_addr = rd_addr;
        end else if (wr_req & ~rst) begin
            mem_addr  = wr_addr;
            mem_we    = 1'b1;
            mem_wdata = wr_data;
            wr_ack    = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:  if (fs) state_nxt = S_FETCH;
            S_FETCH: begin
                if (fs)
                    state_nxt = S_FETCH;
                else if (rd_issue && (({1'b0, rd_addr} + (AW+1)'(1)) == TOTAL))
                    state_nxt = S_DONE;
            end
            S_DONE:  if (fs) state_nxt = S_FETCH;
            default: state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state    <= S_WAIT;
            vs_q     <= 1'b0;
            rd_addr  <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            vs_q     <= vs;
            inflight <= rd_issue;
            if (fs)
                rd_addr <= '0;
            else if (rd_issue)
                rd_addr <= rd_addr + AW'(1);
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else if (fs) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            count <= count + (PW+1)'(store) - (PW+1)'(deq);
            if (store) wptr <= wptr + PW'(1);
            if (deq)   rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (store)
            fifo_mem[wptr] <= mem_rdata;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pix_out   <= '0;
            pix_valid <= 1'b0;
        end else if (pop) begin
            pix_valid <= 1'b1;
            if (!fifo_empty)
                pix_out <= fifo_mem[rptr];
            else if (push)
                pix_out <= mem_rdata;
            else
                pix_out <= '0;
        end else begin
            pix_out   <= '0;
            pix_valid <= 1'b0;
        end
    end

`ifdef FB_SCHED_UNDERFLOW_EN
    always_ff @(posedge pclk or posedge rst) begin
        if (rst)
            underflow <= 1'b0;
        else if (pop & fifo_empty & ~push)
            underflow <= 1'b1;
    end
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fb_read_scheduler.sv
// Directed bench for fb_read_scheduler: 8x2 frame, depth-4 FIFO, RAM preloaded with data = addr.
module tb_fb_read_scheduler;
    localparam int H_ACT = 8;
    localparam int V_ACT = 2;
    localparam int AW    = 5;
    localparam int DW    = 12;
    localparam int DEPTH = 4;
`ifdef FB_SCHED_UNDERFLOW_EN
    localparam logic EXP_UF = 1'b1;
`else
    localparam logic EXP_UF = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          rst;
    logic          hen, ven, vs;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_out;
    logic          pix_valid;
    logic          underflow;

    logic [DW-1:0] ram [32];
    logic          ram_init;
    int            checks = 0;
    int            errors = 0;

    fb_read_scheduler #(.H_ACT(H_ACT), .V_ACT(V_ACT), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .pclk(pclk), .rst(rst), .hen(hen), .ven(ven), .vs(vs),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_out(pix_out), .pix_valid(pix_valid), .underflow(underflow)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (ram_init) begin
            for (int i = 0; i < 32; i++) ram[i] <= DW'(i);
            mem_rdata <= '0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ram_init = 1'b1;
        hen = 0; ven = 0; vs = 0; wr_req = 0; wr_addr = '0; wr_data = '0;
        #2;
        checks++;
        if ({wr_ack, mem_we, mem_addr, mem_wdata, pix_out, pix_valid, underflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%0b we=%0b addr=%0d wdata=%0h pix=%0h pv=%0b uf=%0b want all 0",
                     wr_ack, mem_we, mem_addr, mem_wdata, pix_out, pix_valid, underflow);
        end
        tick; tick;
        rst = 1'b0; ram_init = 1'b0;
        #1;
        checks++;
        if ({mem_we, mem_addr, wr_ack, pix_valid} !== '0) begin
            errors++;
            $display("FAIL release_idle: got we=%0b addr=%0d ack=%0b pv=%0b want 0", mem_we, mem_addr, wr_ack, pix_valid);
        end
    endtask

    task automatic test_write_wait;
        wr_req = 1; wr_addr = 5'd20; wr_data = 12'h123;
        #1;
        checks++;
        if ({wr_ack, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 5'd20, 12'h123}) begin
            errors++;
            $display("FAIL wait_write_grant: got ack=%0b we=%0b addr=%0d wdata=%0h want 1 1 20 123",
                     wr_ack, mem_we, mem_addr, mem_wdata);
        end
        tick;
        wr_req = 0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL wait_single_pulse: got we=%0b ack=%0b want 0 0", mem_we, wr_ack);
        end
        checks++;
        if (ram[20] !== 12'h123) begin
            errors++;
            $display("FAIL wait_ram_write: got %0h want 123", ram[20]);
        end
    endtask

    task automatic pulse_vs;
        vs = 1;
        tick;
        vs = 0;
    endtask

    task automatic test_prefetch_frame;
        pulse_vs;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (mem_addr !== AW'(i < 4 ? i : 0) || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL prefetch_addr[%0d]: got addr=%0d we=%0b want addr=%0d we=0",
                         i, mem_addr, mem_we, (i < 4 ? i : 0));
            end
            tick;
        end
        hen = 1; ven = 1;
        for (int i = 0; i < 16; i++) begin
            tick;
            if (i == 15) begin hen = 0; ven = 0; end
            checks++;
            if (pix_out !== DW'(i) || pix_valid !== 1'b1 || underflow !== 1'b0) begin
                errors++;
                $display("FAIL frame_pixel[%0d]: got pix=%0h pv=%0b uf=%0b want pix=%0h pv=1 uf=0",
                         i, pix_out, pix_valid, underflow, i);
            end
        end
        tick;
        checks++;
        if (pix_valid !== 1'b0 || pix_out !== '0) begin
            errors++;
            $display("FAIL frame_end_idle: got pv=%0b pix=%0h want 0 0", pix_valid, pix_out);
        end
    endtask

    task automatic test_write_stall;
        pulse_vs;
        repeat (6) tick;
        hen = 1; ven = 1;
        wr_req = 1; wr_addr = 5'd5; wr_data = 12'hABC;
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++;
            if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL stall_no_ack[%0d]: got ack=%0b we=%0b want 0 0", i, wr_ack, mem_we);
            end
            tick;
        end
        #1;
        checks++;
        if ({wr_ack, mem_we, mem_addr} !== {1'b1, 1'b1, 5'd5}) begin
            errors++;
            $display("FAIL stall_first_gap: got ack=%0b we=%0b addr=%0d want 1 1 5", wr_ack, mem_we, mem_addr);
        end
        tick;
        wr_req = 0;
        checks++;
        if (ram[5] !== 12'hABC) begin
            errors++;
            $display("FAIL stall_ram_write: got %0h want abc", ram[5]);
        end
        repeat (3) tick;
        hen = 0; ven = 0;
        checks++;
        if (pix_out !== 12'd15 || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_last_pixel: got pix=%0h pv=%0b want f 1", pix_out, pix_valid);
        end
        tick;
    endtask

    task automatic test_write_done;
        wr_req = 1; wr_addr = 5'd21; wr_data = 12'h456;
        #1;
        checks++;
        if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 5'd21) begin
            errors++;
            $display("FAIL done_write_grant: got ack=%0b we=%0b addr=%0d want 1 1 21", wr_ack, mem_we, mem_addr);
        end
        tick;
        wr_req = 0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || ram[21] !== 12'h456) begin
            errors++;
            $display("FAIL done_write_once: got we=%0b ram=%0h want 0 456", mem_we, ram[21]);
        end
    endtask

    task automatic test_underflow;
        vs = 1;
        tick;
        vs = 0; hen = 1; ven = 1;
        tick;
        hen = 0; ven = 0;
        checks++;
        if (pix_out !== '0 || pix_valid !== 1'b1 || underflow !== EXP_UF) begin
            errors++;
            $display("FAIL underflow_pixel: got pix=%0h pv=%0b uf=%0b want 0 1 %0b", pix_out, pix_valid, underflow, EXP_UF);
        end
        tick;
        checks++;
        if (underflow !== EXP_UF || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL underflow_sticky: got uf=%0b pv=%0b want %0b 0", underflow, pix_valid, EXP_UF);
        end
    endtask

    task automatic test_restart;
        repeat (4) tick;
        hen = 1; ven = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (pix_out !== DW'(i) || pix_valid !== 1'b1) begin
                errors++;
                $display("FAIL pre_restart_pixel[%0d]: got pix=%0h pv=%0b want %0h 1", i, pix_out, pix_valid, i);
            end
        end
        hen = 0; ven = 0; vs = 1;
        #1;
        checks++;
        if (mem_addr !== '0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL fs_no_read: got addr=%0d we=%0b want 0 0", mem_addr, mem_we);
        end
        tick;
        vs = 0;
        repeat (6) tick;
        hen = 1; ven = 1;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++;
            if (pix_out !== DW'(i) || pix_valid !== 1'b1) begin
                errors++;
                $display("FAIL restart_pixel[%0d]: got pix=%0h pv=%0b want %0h 1", i, pix_out, pix_valid, i);
            end
        end
    endtask

    task automatic test_reset_mid;
        wr_req = 1; wr_addr = 5'd22; wr_data = 12'h789;
        tick;
        #1;
        checks++;
        if (wr_ack !== 1'b0 || pix_valid !== 1'b1 || pix_out !== 12'd2) begin
            errors++;
            $display("FAIL mid_before_rst: got ack=%0b pv=%0b pix=%0h want 0 1 2", wr_ack, pix_valid, pix_out);
        end
        #1;
        rst = 1;
        #1;
        checks++;
        if ({wr_ack, mem_we, mem_addr, mem_wdata, pix_out, pix_valid, underflow} !== '0) begin
            errors++;
            $display("FAIL mid_async_reset: got ack=%0b we=%0b addr=%0d wdata=%0h pix=%0h pv=%0b uf=%0b want all 0",
                     wr_ack, mem_we, mem_addr, mem_wdata, pix_out, pix_valid, underflow);
        end
        hen = 0; ven = 0;
        tick;
        rst = 0;
        #1;
        checks++;
        if ({wr_ack, mem_we, mem_addr} !== {1'b1, 1'b1, 5'd22}) begin
            errors++;
            $display("FAIL post_reset_grant: got ack=%0b we=%0b addr=%0d want 1 1 22", wr_ack, mem_we, mem_addr);
        end
        tick;
        wr_req = 0;
        #1;
        checks++;
        if (ram[22] !== 12'h789 || mem_we !== 1'b0 || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_write: got ram=%0h we=%0b pv=%0b want 789 0 0", ram[22], mem_we, pix_valid);
        end
    endtask

    initial begin
        test_reset;
        test_write_wait;
        test_prefetch_frame;
        test_write_stall;
        test_write_done;
        test_underflow;
        test_restart;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
